// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared constants, opcode and FSM state encodings for the ALU
//            execute stage, plus a register-address range helper.
// Config   : ALU_EXEC_MUL_EN selects the iterative multiplier (see top).
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int DATA_W     = 16;
    localparam int ADDR_W     = 4;
    localparam int NUM_REGS   = 8;
    localparam int MUL_CYCLES = DATA_W;
    localparam int OP_W       = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SHL = 3'd5,
        OP_SHR = 3'd6,
        OP_MUL = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_WB   = 2'd2
    } state_e;

    // True when the destination is backed by a physical register.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] addr);
        return (addr < ADDR_W'(NUM_REGS));
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_exec_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_stage_if
// Purpose  : Issue (decode -> execute) handshake and register-file writeback
//            bundle of the ALU execute stage.
// Ports    : in_valid/in_ready/op/opa/opb/dst  - issue handshake
//            wb_en/wb_addr/wb_data             - writeback to register file
// Modports : master = decode / register-file side, slave = execute stage
// Revision : 1.0 - initial release
// ============================================================================
interface alu_exec_stage_if;
    import alu_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;
    logic [ADDR_W-1:0] dst;
    logic              wb_en;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;

    modport master (
        output in_valid, op, opa, opb, dst,
        input  in_ready, wb_en, wb_addr, wb_data
    );

    modport slave (
        input  in_valid, op, opa, opb, dst,
        output in_ready, wb_en, wb_addr, wb_data
    );

endinterface
`default_nettype wire

// File: rtl/alu_seq_mul.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_mul
// Purpose  : Iterative unsigned shift-add multiplier, one partial product per
//            clock, MUL_CYCLES iterations, result truncated to DATA_W.
// Ports    : clk, rst_n (async active-low), start (load operands a/b),
//            done (high during the final iteration), product (valid with done)
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq_mul
    import alu_pkg::*;
#(
    parameter int DATA_W     = alu_pkg::DATA_W,
    parameter int MUL_CYCLES = alu_pkg::MUL_CYCLES
) (
    input  wire                clk,
    input  wire                rst_n,
    input  wire                start,
    input  wire   [DATA_W-1:0] a,
    input  wire   [DATA_W-1:0] b,
    output logic               done,
    output logic  [DATA_W-1:0] product
);

    localparam int CNT_W = $clog2(MUL_CYCLES + 1);

    logic              r_busy;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] r_mcand;
    logic [DATA_W-1:0] r_mplier;
    logic [DATA_W-1:0] w_acc_next;
    logic              w_last;

    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign w_last     = r_busy && (r_cnt == CNT_W'(MUL_CYCLES - 1));

    // The final partial sum is forwarded combinationally so the caller can
    // register it on the same edge that retires the last iteration.
    assign done    = w_last;
    assign product = w_acc_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (start) begin
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= a;
            r_mplier <= b;
        end else if (r_busy) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_exec_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_stage
// Purpose  : Execute stage between register-file read and write ports.
//            Single-cycle ADD/SUB/AND/OR/XOR/SHL/SHR, optional iterative MUL,
//            registered one-cycle writeback pulse.
// Ports    : clk, rst_n (async active-low)
//            bus       - alu_exec_stage_if.slave (issue + writeback)
//            carry     - carry/borrow of last completed ADD/SUB
//            addr_err  - sticky: writeback to an unimplemented register dropped
//            illegal_op- one-cycle pulse: unsupported op accepted
// Config   : `define ALU_EXEC_MUL_EN to build the multiplier; otherwise op 7
//            is retired without writeback and flagged on illegal_op.
// Revision : 1.0 - initial release
// ============================================================================
module alu_exec_stage
    import alu_pkg::*;
(
    input  wire              clk,
    input  wire              rst_n,
    alu_exec_stage_if.slave  bus,
    output logic             carry,
    output logic             addr_err,
    output logic             illegal_op
);

    state_e            r_state,    w_state_next;
    logic              r_wb_en,    w_wb_en_next;
    logic [ADDR_W-1:0] r_wb_addr,  w_wb_addr_next;
    logic [DATA_W-1:0] r_wb_data,  w_wb_data_next;
    logic              r_carry,    w_carry_next;
    logic              r_addr_err, w_addr_err_next;
    logic              r_illegal,  w_illegal_next;
    logic              w_in_ready;
    logic              w_accept;
    logic [DATA_W-1:0] w_alu_result;
    logic              w_alu_carry;
    logic [DATA_W:0]   w_sum;

`ifdef ALU_EXEC_MUL_EN
    logic [ADDR_W-1:0] r_dst, w_dst_next;
    logic              w_mul_start;
    logic              w_mul_done;
    logic [DATA_W-1:0] w_mul_product;

    alu_seq_mul #(
        .DATA_W     (DATA_W),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (w_mul_start),
        .a       (bus.opa),
        .b       (bus.opb),
        .done    (w_mul_done),
        .product (w_mul_product)
    );

    assign w_in_ready = (r_state != S_MUL);
`else
    assign w_in_ready = 1'b1;
`endif

    assign w_accept     = bus.in_valid & w_in_ready;
    assign bus.in_ready = w_in_ready;
    assign bus.wb_en    = r_wb_en;
    assign bus.wb_addr  = r_wb_addr;
    assign bus.wb_data  = r_wb_data;
    assign carry        = r_carry;
    assign addr_err     = r_addr_err;
    assign illegal_op   = r_illegal;

    // Single-cycle datapath; carry is the extra bit of a DATA_W+1 sum, which
    // for SUB is the borrow (opa < opb unsigned).
    always_comb begin
        w_alu_result = '0;
        w_alu_carry  = 1'b0;
        w_sum        = '0;
        case (bus.op)
            OP_ADD: begin
                w_sum        = {1'b0, bus.opa} + {1'b0, bus.opb};
                w_alu_result = w_sum[DATA_W-1:0];
                w_alu_carry  = w_sum[DATA_W];
            end
            OP_SUB: begin
                w_sum        = {1'b0, bus.opa} - {1'b0, bus.opb};
                w_alu_result = w_sum[DATA_W-1:0];
                w_alu_carry  = w_sum[DATA_W];
            end
            OP_AND:  w_alu_result = bus.opa & bus.opb;
            OP_OR:   w_alu_result = bus.opa | bus.opb;
            OP_XOR:  w_alu_result = bus.opa ^ bus.opb;
            OP_SHL:  w_alu_result = bus.opa << bus.opb[3:0];
            OP_SHR:  w_alu_result = bus.opa >> bus.opb[3:0];
            default: w_alu_result = '0;
        endcase
    end

    // Next-state and output logic. IDLE and WB behave identically for new
    // issues (WB simply also shows the multiplier writeback), so both share
    // the default branch.
    always_comb begin
        w_state_next    = r_state;
        w_wb_en_next    = 1'b0;
        w_wb_addr_next  = r_wb_addr;
        w_wb_data_next  = r_wb_data;
        w_carry_next    = r_carry;
        w_addr_err_next = r_addr_err;
        w_illegal_next  = 1'b0;
`ifdef ALU_EXEC_MUL_EN
        w_dst_next      = r_dst;
        w_mul_start     = 1'b0;
`endif
        case (r_state)
`ifdef ALU_EXEC_MUL_EN
            S_MUL: begin
                if (w_mul_done) begin
                    w_state_next   = S_WB;
                    w_wb_addr_next = r_dst;
                    w_wb_data_next = w_mul_product;
                    w_wb_en_next   = addr_ok(r_dst);
                    if (!addr_ok(r_dst)) begin
                        w_addr_err_next = 1'b1;
                    end
                end
            end
`endif
            default: begin
                w_state_next = S_IDLE;
                if (w_accept) begin
                    if (bus.op == OP_MUL) begin
`ifdef ALU_EXEC_MUL_EN
                        w_state_next = S_MUL;
                        w_mul_start  = 1'b1;
                        w_dst_next   = bus.dst;
`else
                        w_illegal_next = 1'b1;
`endif
                    end else begin
                        w_wb_addr_next = bus.dst;
                        w_wb_data_next = w_alu_result;
                        w_wb_en_next   = addr_ok(bus.dst);
                        if (!addr_ok(bus.dst)) begin
                            w_addr_err_next = 1'b1;
                        end
                        if ((bus.op == OP_ADD) || (bus.op == OP_SUB)) begin
                            w_carry_next = w_alu_carry;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_wb_en    <= 1'b0;
            r_wb_addr  <= '0;
            r_wb_data  <= '0;
            r_carry    <= 1'b0;
            r_addr_err <= 1'b0;
            r_illegal  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_wb_en    <= w_wb_en_next;
            r_wb_addr  <= w_wb_addr_next;
            r_wb_data  <= w_wb_data_next;
            r_carry    <= w_carry_next;
            r_addr_err <= w_addr_err_next;
            r_illegal  <= w_illegal_next;
        end
    end

`ifdef ALU_EXEC_MUL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dst <= '0;
        end else begin
            r_dst <= w_dst_next;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_exec_stage
// Purpose  : Self-checking bench for alu_exec_stage: directed vector table,
//            multi-cycle corner sequences and a randomized stream checked
//            against a transaction-level reference model.
// Config   : follows ALU_EXEC_MUL_EN the same way as the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_exec_stage;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic carry, addr_err, illegal_op;

    alu_exec_stage_if bus();

    alu_exec_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .carry      (carry),
        .addr_err   (addr_err),
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_wb_en"},    32'(bus.wb_en),    32'd0);
        chk({tag, "_wb_addr"},  32'(bus.wb_addr),  32'd0);
        chk({tag, "_wb_data"},  32'(bus.wb_data),  32'd0);
        chk({tag, "_carry"},    32'(carry),        32'd0);
        chk({tag, "_addr_err"}, 32'(addr_err),     32'd0);
        chk({tag, "_illegal"},  32'(illegal_op),   32'd0);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] dst);
        bus.in_valid = 1'b1;
        bus.op  = op;
        bus.opa = a;
        bus.opb = b;
        bus.dst = dst;
    endtask

    // Reference arithmetic straight from the operation definitions.
    function automatic void ref_op(input int op, input int unsigned a, input int unsigned b,
                                   output logic [15:0] r, output logic c);
        longint unsigned t;
        c = 1'b0;
        case (op)
            0: begin t = longint'(a) + longint'(b); c = (t > 65535); end
            1: begin t = longint'(a) + 65536 - longint'(b); c = (a < b); end
            2: t = longint'(a & b);
            3: t = longint'(a | b);
            4: t = longint'(a ^ b);
            5: t = longint'(a) << (b % 16);
            6: t = longint'(a >> (b % 16));
            default: t = longint'(a) * longint'(b);
        endcase
        r = t[15:0];
    endfunction

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  dst;
        logic [15:0] data;
        logic        c;
    } vec_t;

    typedef struct {
        int          due;
        bit          ill;
        bit          en;
        logic [3:0]  addr;
        logic [15:0] data;
        bit          upd_c;
        logic        c;
    } ev_t;

    vec_t tbl[11];
    ev_t  evq[$];

    initial begin
        ev_t         ev;
        int          cyc, busy_until;
        bit          pend, acc, e_en, e_ill, e_rdy;
        logic [3:0]  e_addr;
        logic [15:0] e_data, r;
        logic        e_carry, e_aerr, c;

        // expected carry is the value after each op (unchanged by logic ops)
        tbl[0]  = '{3'd0, 16'hFFFF, 16'h0001, 4'd2, 16'h0000, 1'b1};
        tbl[1]  = '{3'd1, 16'h0003, 16'h0005, 4'd3, 16'hFFFE, 1'b1};
        tbl[2]  = '{3'd4, 16'hA5A5, 16'h0FF0, 4'd1, 16'hAA55, 1'b1};
        tbl[3]  = '{3'd5, 16'h0001, 16'h000F, 4'd5, 16'h8000, 1'b1};
        tbl[4]  = '{3'd6, 16'h8000, 16'h0013, 4'd6, 16'h1000, 1'b1};
        tbl[5]  = '{3'd0, 16'h1234, 16'h1111, 4'd0, 16'h2345, 1'b0};
        tbl[6]  = '{3'd2, 16'hF0F0, 16'h3C3C, 4'd7, 16'h3030, 1'b0};
        tbl[7]  = '{3'd3, 16'hF000, 16'h000F, 4'd4, 16'hF00F, 1'b0};
        tbl[8]  = '{3'd1, 16'h0005, 16'h0003, 4'd3, 16'h0002, 1'b0};
        tbl[9]  = '{3'd1, 16'h0000, 16'h0001, 4'd2, 16'hFFFF, 1'b1};
        tbl[10] = '{3'd2, 16'hFFFF, 16'h1234, 4'd7, 16'h1234, 1'b1};

        bus.in_valid = 1'b0;
        bus.op = '0; bus.opa = '0; bus.opb = '0; bus.dst = '0;

        // ---------------- reset values ----------------
        do_reset();
        check_reset_vals("reset");

        // ---------------- back-to-back vector table ----------------
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].dst);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_wb_en", i),    32'(bus.wb_en),    32'd1);
            chk($sformatf("vec%0d_wb_addr", i),  32'(bus.wb_addr),  32'(tbl[i].dst));
            chk($sformatf("vec%0d_wb_data", i),  32'(bus.wb_data),  32'(tbl[i].data));
            chk($sformatf("vec%0d_carry", i),    32'(carry),        32'(tbl[i].c));
            chk($sformatf("vec%0d_in_ready", i), 32'(bus.in_ready), 32'd1);
        end
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_wb_en", 32'(bus.wb_en), 32'd0);

        // ---------------- out-of-range destination ----------------
        drive(3'd0, 16'h0001, 16'h0002, 4'd9);
        @(posedge clk);
        #1;
        chk("badaddr_wb_en",    32'(bus.wb_en),   32'd0);
        chk("badaddr_addr_err", 32'(addr_err),    32'd1);
        chk("badaddr_wb_addr",  32'(bus.wb_addr), 32'd9);
        chk("badaddr_wb_data",  32'(bus.wb_data), 32'd3);
        for (int d = 0; d < 8; d++) begin
            drive(3'd0, 16'(d), 16'h0010, 4'(d));
            @(posedge clk);
            #1;
            chk($sformatf("sticky%0d_wb_en", d),    32'(bus.wb_en), 32'd1);
            chk($sformatf("sticky%0d_addr_err", d), 32'(addr_err),  32'd1);
        end
        bus.in_valid = 1'b0;

        // ---------------- op 7 handling ----------------
        do_reset();
`ifdef ALU_EXEC_MUL_EN
        drive(3'd7, 16'h0123, 16'h0045, 4'd4);
        @(posedge clk);
        #1;
        drive(3'd0, 16'h0002, 16'h0003, 4'd5);   // held while the multiplier runs
        for (int k = 1; k <= 16; k++) begin
            chk($sformatf("mul_busy%0d_in_ready", k), 32'(bus.in_ready), 32'd0);
            chk($sformatf("mul_busy%0d_wb_en", k),    32'(bus.wb_en),    32'd0);
            @(posedge clk);
            #1;
        end
        chk("mul_wb_en",    32'(bus.wb_en),    32'd1);
        chk("mul_wb_addr",  32'(bus.wb_addr),  32'd4);
        chk("mul_wb_data",  32'(bus.wb_data),  32'h4E6F);
        chk("mul_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("mul_then_add_wb_en",   32'(bus.wb_en),   32'd1);
        chk("mul_then_add_wb_addr", 32'(bus.wb_addr), 32'd5);
        chk("mul_then_add_wb_data", 32'(bus.wb_data), 32'd5);
        @(posedge clk);
        #1;
        chk("mul_then_add_idle", 32'(bus.wb_en), 32'd0);
`else
        drive(3'd7, 16'h0123, 16'h0045, 4'd1);
        @(posedge clk);
        #1;
        chk("illegal_pulse",    32'(illegal_op),   32'd1);
        chk("illegal_wb_en",    32'(bus.wb_en),    32'd0);
        chk("illegal_wb_data",  32'(bus.wb_data),  32'd0);
        chk("illegal_in_ready", 32'(bus.in_ready), 32'd1);
        drive(3'd0, 16'h0001, 16'h0001, 4'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("after_illegal_pulse_end", 32'(illegal_op),  32'd0);
        chk("after_illegal_wb_en",     32'(bus.wb_en),   32'd1);
        chk("after_illegal_wb_data",   32'(bus.wb_data), 32'd2);
`endif

        // ---------------- reset held during activity ----------------
        rst_n = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), 4'($urandom_range(0, 15)));
            @(posedge clk);
            #1;
            check_reset_vals($sformatf("rst_active%0d", k));
        end
        bus.in_valid = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

`ifdef ALU_EXEC_MUL_EN
        // ---------------- reset mid-multiply ----------------
        drive(3'd7, 16'h0003, 16'h0004, 4'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        check_reset_vals("mid_mul_rst");
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < 22; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("abort%0d_wb_en", k),    32'(bus.wb_en),    32'd0);
            chk($sformatf("abort%0d_in_ready", k), 32'(bus.in_ready), 32'd1);
        end
`endif

        // ---------------- randomized stream vs reference model ----------------
        do_reset();
        evq.delete();
        cyc = 0; busy_until = -1; pend = 1'b0;
        e_addr = '0; e_data = '0; e_carry = 1'b0; e_aerr = 1'b0;
        for (int n = 0; n < 400; n++) begin
            e_en = 1'b0;
            e_ill = 1'b0;
            if (evq.size() > 0 && evq[0].due == cyc) begin
                ev = evq.pop_front();
                if (ev.ill) begin
                    e_ill = 1'b1;
                end else begin
                    e_addr = ev.addr;
                    e_data = ev.data;
                    e_en   = ev.en;
                    if (!ev.en) e_aerr = 1'b1;
                    if (ev.upd_c) e_carry = ev.c;
                end
            end
            e_rdy = (cyc > busy_until);
            chk($sformatf("rnd%0d_wb_en", cyc),    32'(bus.wb_en),    32'(e_en));
            chk($sformatf("rnd%0d_wb_addr", cyc),  32'(bus.wb_addr),  32'(e_addr));
            chk($sformatf("rnd%0d_wb_data", cyc),  32'(bus.wb_data),  32'(e_data));
            chk($sformatf("rnd%0d_carry", cyc),    32'(carry),        32'(e_carry));
            chk($sformatf("rnd%0d_addr_err", cyc), 32'(addr_err),     32'(e_aerr));
            chk($sformatf("rnd%0d_illegal", cyc),  32'(illegal_op),   32'(e_ill));
            chk($sformatf("rnd%0d_in_ready", cyc), 32'(bus.in_ready), 32'(e_rdy));

            if (!pend) begin
                bus.in_valid = ($urandom_range(0, 3) != 0);
                bus.op  = 3'($urandom_range(0, 7));
                bus.opa = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
                bus.opb = 16'($urandom);
                bus.dst = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(8, 15))
                                                       : 4'($urandom_range(0, 7));
            end
            acc  = bus.in_valid && e_rdy;
            pend = bus.in_valid && !e_rdy;
            if (acc) begin
                ref_op(int'(bus.op), int'(bus.opa), int'(bus.opb), r, c);
                ev.ill   = 1'b0;
                ev.en    = (bus.dst < 4'd8);
                ev.addr  = bus.dst;
                ev.data  = r;
                ev.upd_c = (bus.op == 3'd0) || (bus.op == 3'd1);
                ev.c     = c;
                ev.due   = cyc + 1;
                if (bus.op == 3'd7) begin
`ifdef ALU_EXEC_MUL_EN
                    ev.due     = cyc + 17;
                    busy_until = cyc + 16;
`else
                    ev.ill = 1'b1;
`endif
                end
                evq.push_back(ev);
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.in_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
